// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL bit positions
// and the APB completer state encoding reused by other completers.
package apb_timer_pkg;

  localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
  localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
  localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TMR_CTRL        = 5'h10;
  localparam logic [4:0] TMR_PRESCALE    = 5'h14;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic {
    APB_IDLE,
    APB_ACCESS
  } apb_state_e;

  // Byte i of the result comes from new_val when strb[i] is set, else from old_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Prescaler plus 64-bit mtime counter; a load of either half wins over a tick
// on the same edge, and the other half keeps its pre-edge value.
module timer_counter
  import apb_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] prescale,
  input  logic        presc_clr,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] load_val,
  output logic [63:0] mtime,
  output logic [63:0] mtime_next,
  output logic        tick
);

  logic [31:0] presc_cnt_q, presc_cnt_d;
  logic [63:0] mtime_q, mtime_d;

  assign tick       = en && (presc_cnt_q == prescale);
  assign mtime      = mtime_q;
  assign mtime_next = mtime_d;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (presc_clr || tick) begin
      presc_cnt_d = '0;
    end else if (en) begin
      presc_cnt_d = presc_cnt_q + 32'd1;
    end

    mtime_d = mtime_q;
    if (load_lo) begin
      mtime_d = {mtime_q[63:32], load_val};
    end else if (load_hi) begin
      mtime_d = {load_val, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
      mtime_q     <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      mtime_q     <= mtime_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB completer around a RISC-V style mtime/mtimecmp timer with prescaler,
// configurable wait states and error response for misaligned/unmapped offsets.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESET,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  output logic                  irq
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e      state_q, state_d;
  logic [4:0]      addr_q, addr_d;
  logic            write_q, write_d;
  logic [3:0]      strb_q, strb_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [31:0]     prescale_q, prescale_d;
  logic            irq_q, irq_d;

  logic            addr_err, wr_en, load_lo, load_hi, presc_clr;
  logic [31:0]     load_val, rd_val;
  logic [63:0]     mtime, mtime_next;
  logic            tick_unused;
  logic            unused_paddr;

  assign unused_paddr = ^APB_paddr[ADDR_WIDTH-1:5];

  assign addr_err   = (addr_q[1:0] != 2'b00) || (addr_q > TMR_PRESCALE);
  assign APB_pready = (state_q == APB_ACCESS) && APB_psel && APB_penable && (wait_cnt_q == 4'd0);
  assign APB_perr   = APB_pready && addr_err;
  assign wr_en      = APB_pready && write_q && !addr_err;

  assign load_lo   = wr_en && (addr_q == TMR_MTIME_LO);
  assign load_hi   = wr_en && (addr_q == TMR_MTIME_HI);
  assign presc_clr = wr_en && (addr_q == TMR_PRESCALE);
  assign load_val  = merge_bytes(load_hi ? mtime[63:32] : mtime[31:0], wdata_q, strb_q);

  timer_counter u_counter (
    .clk        (APB_PCLK),
    .rst        (APB_PRESET),
    .en         (ctrl_q[CTRL_EN]),
    .prescale   (prescale_q),
    .presc_clr  (presc_clr),
    .load_lo    (load_lo),
    .load_hi    (load_hi),
    .load_val   (load_val),
    .mtime      (mtime),
    .mtime_next (mtime_next),
    .tick       (tick_unused)
  );

  // Read mux sees pre-edge register values, so a read never observes its own edge's update.
  always_comb begin
    rd_val = '0;
    case (addr_q)
      TMR_MTIME_LO:    rd_val = mtime[31:0];
      TMR_MTIME_HI:    rd_val = mtime[63:32];
      TMR_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      TMR_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      TMR_CTRL:        rd_val = {30'd0, ctrl_q};
      TMR_PRESCALE:    rd_val = prescale_q;
      default:         rd_val = '0;
    endcase
    APB_prdata = (APB_pready && !addr_err) ? rd_val : '0;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      APB_IDLE: begin
        if (APB_psel && !APB_penable) begin
          addr_d     = APB_paddr[4:0];
          write_d    = APB_pwrite;
          strb_d     = APB_pstb;
          wdata_d    = APB_pdata;
          wait_cnt_d = WAIT_INIT;
          state_d    = APB_ACCESS;
        end
      end
      APB_ACCESS: begin
        if (!APB_psel) begin
          state_d = APB_IDLE;
        end else if (APB_penable) begin
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end else begin
            state_d = APB_IDLE;
          end
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // Register file commit; irq compares the values these registers will hold after this edge.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    if (wr_en) begin
      case (addr_q)
        TMR_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_q, strb_q);
        TMR_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_q, strb_q);
        TMR_CTRL:        if (strb_q[0]) ctrl_d = wdata_q[1:0];
        TMR_PRESCALE:    prescale_d = merge_bytes(prescale_q, wdata_q, strb_q);
        default: ;
      endcase
    end
    irq_d = ctrl_d[CTRL_IRQ_EN] && (mtime_next >= mtimecmp_d);
  end

  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      state_q    <= APB_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_q     <= '0;
      prescale_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- APB completer holding a RISC-V style 64-bit machine timer (mtime/mtimecmp) with a programmable prescaler.
- Sits on the CPU's APB requester bus, selected by the system address decoder's APB_psel.
- Drives the CPU `interrupt` input.
- Inserts a parameterised number of wait states and flags bad accesses on APB_perr.

Parameters:
- ADDR_WIDTH, 32, APB address width; only paddr[4:0] is decoded.
- DATA_WIDTH, 32, APB data width; fixed at 32 for this block.
- WAIT_STATES, 1, number of access-phase cycles with pready low before completion (0..15).

Ports:
- APB_PCLK  in  1  clock, rising edge
- APB_PRESET  in  1  asynchronous, active-high reset
- APB_paddr  in  ADDR_WIDTH  byte address
- APB_pdata  in  DATA_WIDTH  write data
- APB_prdata  out  DATA_WIDTH  read data
- APB_psel  in  1  completer select
- APB_penable  in  1  access phase
- APB_pwrite  in  1  1 = write
- APB_pstb  in  4  byte strobes; reads always arrive as 4'b1111
- APB_pready  out  1  transfer complete
- APB_perr  out  1  error response, valid only while pready=1
- irq  out  1  timer interrupt level, to cpu `interrupt`

Behaviour:
- Register map (offset = paddr[4:0]):
  - 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI.
  - 0x10 CTRL: bit0 EN, bit1 IRQ_EN, other bits read 0.
  - 0x14 PRESCALE: 32 bits.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, prescale counter=0.
- Outputs during reset: pready=0, perr=0, prdata=0, irq=0, FSM in IDLE.
- Reset asserted mid-transfer aborts it with no register write.
- FSM states:
  - IDLE: on psel && !penable (setup phase), latch addr, write, strobes and data; load wait_cnt=WAIT_STATES; go to ACCESS.
  - ACCESS: while psel && penable && wait_cnt!=0, decrement wait_cnt. pready is combinational: (state==ACCESS) && psel && penable && wait_cnt==0. On the edge where pready=1, commit the write or capture the read, then go to IDLE.
  - psel dropping while in ACCESS: protocol abort; return to IDLE, no write, pready stays 0.
- Back-to-back transfers: the setup phase of the next transfer follows pready in the next cycle and is accepted from IDLE. Minimum transfer is 2 cycles with WAIT_STATES=0.
- Read data:
  - prdata is driven combinationally from the addressed register while pready=1, else 0.
  - A read returns the register value before any same-edge update.
- Write data: merge per byte. Byte i is updated iff pstb[i]; all other bytes keep their value.
- Errors: perr=1 together with pready when paddr[1:0]!=0 or offset>0x14. The access has no side effect and reads return 0.
- Counter:
  - When EN=1, the prescale counter increments every cycle.
  - When the prescale counter equals PRESCALE it clears to 0, and mtime increments by 1 on that same edge.
  - PRESCALE=0 therefore ticks mtime every cycle.
  - mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
  - When EN=0, both counters hold.
- Simultaneous events:
  - An APB write to MTIME_LO or MTIME_HI on the same edge as a tick: the written value wins for the whole 64-bit mtime and the tick is dropped. The unwritten half keeps its pre-edge value, with no carry.
  - A write to PRESCALE also clears the prescale counter.
- Interrupt:
  - irq is registered: irq <= IRQ_EN && (mtime >= mtimecmp), with an unsigned 64-bit compare using post-update values.
  - irq is a level. It clears only by raising mtimecmp, lowering mtime, or clearing IRQ_EN.
- The block stays APB-responsive regardless of EN.

Decomposition:
- Shared package/defines header (alongside `sys.v`) holds:
  - register offset constants TMR_MTIME_LO..TMR_PRESCALE;
  - CTRL bit indices;
  - FSM state encoding APB_IDLE/APB_ACCESS, reusable by later APB completers.
- One natural sub-module: timer_counter (prescaler plus 64-bit mtime with load ports and tick output).
- The APB FSM and register file stay in apb_timer.

Test Plan:
- Reset with WAIT_STATES=1, then read 0x08 and 0x0C -> each returns 32'hFFFF_FFFF. pready is high on the 2nd access cycle, perr=0, irq=0.
- Write 0x14=3, write 0x10=1, wait 40 cycles, read 0x00 -> value is 10 (±1 per documented edge alignment), and mtime advances once per 4 cycles.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3 with PRESCALE=0 -> irq rises on the cycle after mtime reaches 20. Writing MTIMECMP_LO=1000 drops irq one cycle later.
- Write 0x00 with pstb=4'b0010, data 32'hAABBCCDD, over mtime_lo=0 and EN=0 -> MTIME_LO reads 32'h0000CC00.
- Read 0x18 and write 0x02 -> perr=1 with pready, prdata=0, all registers unchanged.
- Write MTIME_LO=32'hFFFF_FFFF with EN=1 and PRESCALE=0, then observe -> MTIME_HI increments to 1 one cycle after the write.
- Deassert psel mid-ACCESS with WAIT_STATES=3 -> no write and pready never asserted.
- Assert APB_PRESET mid-ACCESS -> pready and prdata return to 0 immediately.
